// File: rtl/sseg_pkg.sv
// Shared constants, state encoding and character codes for the
// seven-segment scan controller.
package sseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [7:0] SSEG_OFF = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        SHOW
    } state_e;

    localparam logic [4:0] CH_G = 5'd16;
    localparam logic [4:0] CH_O = 5'd22;
    localparam logic [4:0] CH_U = 5'd27;
    localparam logic [4:0] CH_Z = 5'd29;
    localparam logic [4:0] CH_BLANK = 5'd31;

    // Digit 0 is the leftmost position and lives on anode[3].
    function automatic logic [3:0] digit_anode(input logic [1:0] d);
        return ~(4'b1000 >> d);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot timer: pulses slot_end on the last cycle of every
// DIGIT_CYCLES-long slot.
module scan_tick_gen #(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign slot_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (slot_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sseg_scan_controller.sv
// Four-digit multiplexed display scanner: one ROM fetch per digit slot,
// message buffer with optional scrolling for messages longer than four.
module sseg_scan_controller
    import sseg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int SCROLL_FRAMES = 250,
    parameter int MSG_DEPTH = 16,
    parameter logic [4:0] BLANK_ADDR = 5'd31
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         msg_we,
    input  logic [$clog2(MSG_DEPTH)-1:0] msg_waddr,
    input  logic [4:0]                   msg_wdata,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         scroll_en,
    output logic [4:0]                   rom_addr,
    input  logic [7:0]                   rom_dout,
    output logic [7:0]                   sseg,
    output logic [3:0]                   anode,
    output logic                         frame_done
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    state_e          state_q, state_d;
    logic [1:0]      digit_q, digit_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   off_q, off_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [4:0]      rom_addr_q, rom_addr_d;
    logic [7:0]      sseg_q, sseg_d;
    logic [3:0]      anode_q, anode_d;
    logic [4:0]      buf_q [MSG_DEPTH];

    logic            slot_end;
    logic [LW-1:0]   off_inc;
    logic [LW-1:0]   nxt_off;
    logic [FW-1:0]   nxt_cnt;
    logic            frame_edge;
    logic [1:0]      sel_digit;
    logic [LW-1:0]   sel_len;
    logic [LW-1:0]   sel_off;
    logic [LW-1:0]   sum;
    logic [4:0]      code;

    scan_tick_gen #(
        .DIGIT_CYCLES(DIGIT_CYCLES)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .slot_end(slot_end)
    );

    // Scroll step and offset sanitising applied at each frame boundary.
    always_comb begin
        nxt_cnt = fcnt_q;
        nxt_off = off_q;
        off_inc = off_q + 1'b1;
        if (scroll_en && (len_q > LW'(NUM_DIGITS))) begin
            if (fcnt_q == FW'(SCROLL_FRAMES - 1)) begin
                nxt_cnt = '0;
                nxt_off = (off_inc >= len_q) ? '0 : off_inc;
            end else begin
                nxt_cnt = fcnt_q + 1'b1;
            end
        end
        if (!scroll_en || (msg_len <= LW'(NUM_DIGITS))) begin
            nxt_off = '0;
            nxt_cnt = '0;
        end
        if (msg_len <= nxt_off) begin
            nxt_off = '0;
        end
    end

    // Code for the upcoming slot; frame-start values apply for digit 0.
    always_comb begin
        frame_edge = (digit_q == 2'd3);
        sel_digit  = digit_q + 2'd1;
        sel_len    = frame_edge ? msg_len : len_q;
        sel_off    = frame_edge ? nxt_off : off_q;
        sum        = sel_off + LW'(sel_digit);
        if (sum >= sel_len) begin
            sum = sum - sel_len;
        end
        code = buf_q[AW'(sum)];
        if ((sel_len == '0) || (LW'(sel_digit) >= sel_len)) begin
            code = BLANK_ADDR;
        end
    end

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        len_d      = len_q;
        off_d      = off_q;
        fcnt_d     = fcnt_q;
        rom_addr_d = rom_addr_q;
        sseg_d     = sseg_q;
        anode_d    = anode_q;
        frame_done = 1'b0;
        unique case (state_q)
            FETCH: begin
                state_d = WAIT;
                anode_d = ANODE_OFF;
            end
            WAIT: begin
                state_d = SHOW;
                sseg_d  = rom_dout;
                anode_d = digit_anode(digit_q);
            end
            SHOW: begin
                if (slot_end) begin
                    state_d    = FETCH;
                    digit_d    = sel_digit;
                    anode_d    = ANODE_OFF;
                    rom_addr_d = code;
                    if (frame_edge) begin
                        frame_done = 1'b1;
                        len_d      = msg_len;
                        off_d      = nxt_off;
                        fcnt_d     = nxt_cnt;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            digit_q    <= '0;
            len_q      <= '0;
            off_q      <= '0;
            fcnt_q     <= '0;
            rom_addr_q <= BLANK_ADDR;
            sseg_q     <= SSEG_OFF;
            anode_q    <= ANODE_OFF;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            len_q      <= len_d;
            off_q      <= off_d;
            fcnt_q     <= fcnt_d;
            rom_addr_q <= rom_addr_d;
            sseg_q     <= sseg_d;
            anode_q    <= anode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                buf_q[i] <= BLANK_ADDR;
            end
        end else if (msg_we) begin
            buf_q[msg_waddr] <= msg_wdata;
        end
    end

    assign rom_addr = rom_addr_q;
    assign sseg     = sseg_q;
    assign anode    = anode_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with a behavioural
// one-cycle character ROM.
module tb_sseg_scan_controller;

    logic       clk;
    logic       rst;
    logic       msg_we;
    logic [3:0] msg_waddr;
    logic [4:0] msg_wdata;
    logic [4:0] msg_len;
    logic       scroll_en;
    logic [4:0] rom_addr;
    logic [7:0] rom_dout;
    logic [7:0] sseg;
    logic [3:0] anode;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    logic [3:0] an_exp [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [4:0] msg [6] = '{5'd22, 5'd16, 5'd27, 5'd29, 5'd1, 5'd2};

    sseg_scan_controller #(
        .DIGIT_CYCLES (8),
        .SCROLL_FRAMES(2),
        .MSG_DEPTH    (16),
        .BLANK_ADDR   (5'd31)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_we    (msg_we),
        .msg_waddr (msg_waddr),
        .msg_wdata (msg_wdata),
        .msg_len   (msg_len),
        .scroll_en (scroll_en),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .sseg      (sseg),
        .anode     (anode),
        .frame_done(frame_done)
    );

    function automatic logic [7:0] rom_fn(input logic [4:0] a);
        return (a == 5'd31) ? 8'hFF : {~a, 3'b010};
    endfunction

    always @(posedge clk) rom_dout <= rom_fn(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in the FETCH cycle of digit d; leaves at the next FETCH.
    task automatic slot(input int d, input logic [4:0] code,
                        input logic we, input logic [3:0] wa,
                        input logic [4:0] wd);
        chk($sformatf("addr d%0d", d), 32'(rom_addr), 32'(code));
        chk($sformatf("dark0 d%0d", d), 32'(anode), 32'hF);
        msg_we = we;
        msg_waddr = wa;
        msg_wdata = wd;
        tick();
        msg_we = 1'b0;
        chk($sformatf("dark1 d%0d", d), 32'(anode), 32'hF);
        tick();
        for (int c = 2; c < 8; c++) begin
            chk($sformatf("sseg d%0d c%0d", d, c), 32'(sseg),
                32'(rom_fn(code)));
            chk($sformatf("anode d%0d c%0d", d, c), 32'(anode),
                32'(an_exp[d]));
            chk($sformatf("fdone d%0d c%0d", d, c), 32'(frame_done),
                32'((d == 3) && (c == 7)));
            tick();
        end
    endtask

    task automatic frame4(input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [4:0] e);
        slot(0, a, 1'b0, 4'd0, 5'd0);
        slot(1, b, 1'b0, 4'd0, 5'd0);
        slot(2, c, 1'b0, 4'd0, 5'd0);
        slot(3, e, 1'b0, 4'd0, 5'd0);
    endtask

    initial begin
        int off;
        rst = 1'b1;
        msg_we = 1'b0;
        msg_waddr = '0;
        msg_wdata = '0;
        msg_len = '0;
        scroll_en = 1'b0;
        tick();
        tick();
        chk("rst addr", 32'(rom_addr), 32'd31);
        chk("rst sseg", 32'(sseg), 32'hFF);
        chk("rst anode", 32'(anode), 32'hF);
        chk("rst fdone", 32'(frame_done), 32'd0);
        rst = 1'b0;
        msg_len = 5'd4;

        // Frame 0: still blank; load O G U Z
        slot(0, 5'd31, 1'b1, 4'd0, 5'd22);
        slot(1, 5'd31, 1'b1, 4'd1, 5'd16);
        slot(2, 5'd31, 1'b1, 4'd2, 5'd27);
        slot(3, 5'd31, 1'b1, 4'd3, 5'd29);

        // Frame 1: OGUZ, length change mid-frame is deferred
        slot(0, 5'd22, 1'b0, 4'd0, 5'd0);
        msg_len = 5'd2;
        slot(1, 5'd16, 1'b0, 4'd0, 5'd0);
        slot(2, 5'd27, 1'b0, 4'd0, 5'd0);
        slot(3, 5'd29, 1'b0, 4'd0, 5'd0);

        frame4(5'd22, 5'd16, 5'd31, 5'd31);

        slot(0, 5'd22, 1'b1, 4'd4, 5'd1);
        slot(1, 5'd16, 1'b1, 4'd5, 5'd2);
        msg_len = 5'd6;
        scroll_en = 1'b1;
        slot(2, 5'd31, 1'b0, 4'd0, 5'd0);
        slot(3, 5'd31, 1'b0, 4'd0, 5'd0);

        // Frames 4..25: offset steps every 2 frames, wraps 5 -> 0
        for (int f = 4; f < 26; f++) begin
            off = ((f - 4) / 2) % 6;
            frame4(msg[off % 6], msg[(off + 1) % 6],
                   msg[(off + 2) % 6], msg[(off + 3) % 6]);
        end

        // Frame 26 at offset 5; shrink to 5 forces offset 0
        slot(0, 5'd2, 1'b0, 4'd0, 5'd0);
        msg_len = 5'd5;
        slot(1, 5'd22, 1'b0, 4'd0, 5'd0);
        slot(2, 5'd16, 1'b0, 4'd0, 5'd0);
        slot(3, 5'd27, 1'b0, 4'd0, 5'd0);

        slot(0, 5'd22, 1'b0, 4'd0, 5'd0);
        scroll_en = 1'b0;
        slot(1, 5'd16, 1'b0, 4'd0, 5'd0);
        slot(2, 5'd27, 1'b0, 4'd0, 5'd0);
        slot(3, 5'd29, 1'b0, 4'd0, 5'd0);

        slot(0, 5'd22, 1'b0, 4'd0, 5'd0);
        msg_len = 5'd4;
        slot(1, 5'd16, 1'b0, 4'd0, 5'd0);
        slot(2, 5'd27, 1'b0, 4'd0, 5'd0);
        slot(3, 5'd29, 1'b0, 4'd0, 5'd0);

        // Write to the entry being fetched: old code now, new next frame
        slot(0, 5'd22, 1'b0, 4'd0, 5'd0);
        slot(1, 5'd16, 1'b0, 4'd0, 5'd0);
        slot(2, 5'd27, 1'b1, 4'd2, 5'd5);
        slot(3, 5'd29, 1'b0, 4'd0, 5'd0);

        frame4(5'd22, 5'd16, 5'd5, 5'd29);

        // Reset asserted inside a SHOW cycle
        slot(0, 5'd22, 1'b0, 4'd0, 5'd0);
        chk("pre-rst addr", 32'(rom_addr), 32'd16);
        tick();
        tick();
        chk("pre-rst anode", 32'(anode), 32'hB);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid-rst sseg", 32'(sseg), 32'hFF);
        chk("mid-rst anode", 32'(anode), 32'hF);
        chk("mid-rst addr", 32'(rom_addr), 32'd31);
        chk("mid-rst fdone", 32'(frame_done), 32'd0);
        rst = 1'b0;
        frame4(5'd31, 5'd31, 5'd31, 5'd31);
        frame4(5'd31, 5'd31, 5'd31, 5'd31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
